// File: rtl/gpio_debounce_pkg.sv
// Shared definitions for the GPIO switch debouncer: default debounce period
// and the counter type used at the default counter width.
package gpio_defs;

    localparam int unsigned GPIO_CNT_W      = 20;
    localparam int unsigned DEB_CYCLES_10MS = 1_000_000;  // 10 ms at 100 MHz

    typedef logic [GPIO_CNT_W-1:0] gpio_deb_cnt_t;

endpackage

// File: rtl/gpio_debounce_bit.sv
// Single-bit synchroniser, stability counter and debounced level flop.
// Edge pulse flops exist only when GPIO_DEBOUNCE_IRQ_EN is defined.
module gpio_debounce_bit #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned DEB_CYCLES  = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_q;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_q = sync[SYNC_STAGES-1];

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (sync_q == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb <= sync_q;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic deb_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_d <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            deb_d <= deb;
            rise  <= deb & ~deb_d;
            fall  <= ~deb & deb_d;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/gpio_debounce.sv
// Per-bit synchronise and debounce of board switch pins, with optional sticky
// edge interrupts (enabled by defining GPIO_DEBOUNCE_IRQ_EN).
module gpio_debounce
    import gpio_defs::*;
#(
    parameter int unsigned NUM_IN      = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = GPIO_CNT_W,
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_10MS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] raw_i,
    output logic [NUM_IN-1:0] deb_o,
    output logic [NUM_IN-1:0] rise_o,
    output logic [NUM_IN-1:0] fall_o,
    input  logic [NUM_IN-1:0] irq_en_i,
    input  logic [NUM_IN-1:0] irq_clr_i,
    output logic [NUM_IN-1:0] irq_pend_o,
    output logic              irq_o
);

    logic [NUM_IN-1:0] rise;
    logic [NUM_IN-1:0] fall;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_bit
        gpio_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_i[i]),
            .deb  (deb_o[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign rise_o = rise;
    assign fall_o = fall;

`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic [NUM_IN-1:0] pend;

    // A new edge wins over a simultaneous clear so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~irq_clr_i) | rise | fall;
        end
    end

    assign irq_pend_o = pend;
    assign irq_o      = |(pend & irq_en_i);
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{irq_en_i, irq_clr_i};
    assign irq_pend_o        = '0;
    assign irq_o             = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench for gpio_debounce (NUM_IN=4, SYNC_STAGES=2, DEB_CYCLES=4);
// expectations follow GPIO_DEBOUNCE_IRQ_EN when it is defined for the build.
module tb_gpio_debounce;

    localparam int unsigned N    = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned HLEN = SYNC - 1 + DEB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] raw_i = '0;
    logic [N-1:0] irq_en_i = '0;
    logic [N-1:0] irq_clr_i = '0;
    logic [N-1:0] deb_o, rise_o, fall_o, irq_pend_o;
    logic         irq_o;

    gpio_debounce #(
        .NUM_IN      (N),
        .SYNC_STAGES (SYNC),
        .CNT_W       (20),
        .DEB_CYCLES  (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_i      (raw_i),
        .deb_o      (deb_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .irq_en_i   (irq_en_i),
        .irq_clr_i  (irq_clr_i),
        .irq_pend_o (irq_pend_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] deb;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] pend;
        logic         irq;
    } obs_t;

    obs_t exp_q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: samp[0] is the most recent raw sample; a bit's accepted
    // level flips once DEB consecutive synchronised samples all disagree with it.
    logic [N-1:0] samp[$];
    logic [N-1:0] m_deb, m_deb_prev, m_rise, m_fall, m_pend;

    task automatic model_reset();
        samp.delete();
        for (int i = 0; i < HLEN; i++) samp.push_back('0);
        m_deb = '0; m_deb_prev = '0; m_rise = '0; m_fall = '0; m_pend = '0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] clr);
        logic [N-1:0] nd, nr, nf, np, s;
        logic         flip;
        nr = m_deb & ~m_deb_prev;
        nf = ~m_deb & m_deb_prev;
        np = (m_pend & ~clr) | m_rise | m_fall;
        nd = m_deb;
        for (int b = 0; b < N; b++) begin
            flip = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                s = samp[SYNC-1+j];
                if (s[b] == m_deb[b]) flip = 1'b0;
            end
            if (flip) nd[b] = ~m_deb[b];
        end
        samp.push_front(r);
        void'(samp.pop_back());
        m_deb_prev = m_deb;
        m_deb      = nd;
        m_rise     = nr;
        m_fall     = nf;
        m_pend     = np;
    endtask

    function automatic obs_t expected(input logic [N-1:0] en);
        obs_t e;
        e.deb = m_deb;
`ifdef GPIO_DEBOUNCE_IRQ_EN
        e.rise = m_rise;
        e.fall = m_fall;
        e.pend = m_pend;
        e.irq  = |(m_pend & en);
`else
        e.rise = '0;
        e.fall = '0;
        e.pend = '0;
        e.irq  = 1'b0 & en[0];
`endif
        return e;
    endfunction

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] en,
                        input logic [N-1:0] clr, input logic rs);
        @(negedge clk);
        raw_i     = r;
        irq_en_i  = en;
        irq_clr_i = clr;
        rst       = rs;
        if (rs) model_reset();
        else    model_edge(r, clr);
        exp_q.push_back(expected(en));
    endtask

    obs_t mon_exp, mon_act;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                mon_exp      = exp_q.pop_front();
                mon_act.deb  = deb_o;
                mon_act.rise = rise_o;
                mon_act.fall = fall_o;
                mon_act.pend = irq_pend_o;
                mon_act.irq  = irq_o;
                total++;
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("FAIL outputs t=%0t got deb=%h rise=%h fall=%h pend=%h irq=%b want deb=%h rise=%h fall=%h pend=%h irq=%b",
                             $time, mon_act.deb, mon_act.rise, mon_act.fall, mon_act.pend, mon_act.irq,
                             mon_exp.deb, mon_exp.rise, mon_exp.fall, mon_exp.pend, mon_exp.irq);
                end
            end
        end
    end

    logic [N-1:0] r_rand, en_rand, clr_rand;

    initial begin
        model_reset();

        // Reset with all pins high, then a count interrupted by reset.
        repeat (3) step(4'hF, 4'h0, 4'h0, 1'b1);
        repeat (2) step(4'h0, 4'h0, 4'h0, 1'b0);
        repeat (4) step(4'h1, 4'h0, 4'h0, 1'b0);
        step(4'h1, 4'h0, 4'h0, 1'b1);
        repeat (9) step(4'h1, 4'h0, 4'h0, 1'b0);

        // Clean step on bit 0 from a fresh reset.
        step(4'h0, 4'h0, 4'h0, 1'b1);
        repeat (2) step(4'h0, 4'h0, 4'h0, 1'b0);
        repeat (10) step(4'h1, 4'h0, 4'h0, 1'b0);

        // Bit 1: 3-cycle glitch rejected, 4-cycle pulse accepted.
        repeat (3) step(4'h3, 4'h0, 4'h0, 1'b0);
        repeat (10) step(4'h1, 4'h0, 4'h0, 1'b0);
        repeat (4) step(4'h3, 4'h0, 4'h0, 1'b0);
        repeat (12) step(4'h1, 4'h0, 4'h0, 1'b0);

        // Bit 2 chatter then final hold.
        for (int i = 0; i < 20; i++) step(((i / 2) % 2 != 0) ? 4'h5 : 4'h1, 4'h0, 4'h0, 1'b0);
        repeat (10) step(4'h5, 4'h0, 4'h0, 1'b0);

        // Interrupts: pend on bits 0 and 3, clear bit 0, clear colliding with a fall.
        step(4'h0, 4'h1, 4'h0, 1'b1);
        repeat (2) step(4'h0, 4'h1, 4'h0, 1'b0);
        repeat (10) step(4'h9, 4'h1, 4'h0, 1'b0);
        step(4'h9, 4'h1, 4'h1, 1'b0);
        repeat (2) step(4'h9, 4'h1, 4'h0, 1'b0);
        for (int i = 1; i <= 8; i++) step(4'h8, 4'h1, (i == 8) ? 4'h1 : 4'h0, 1'b0);
        repeat (3) step(4'h8, 4'h1, 4'h0, 1'b0);
        step(4'h8, 4'h1, 4'h1, 1'b0);
        repeat (2) step(4'h8, 4'h1, 4'h0, 1'b0);

        // Randomised traffic with slow-changing pins, sporadic clears and resets.
        r_rand = '0; en_rand = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) r_rand[b] = ~r_rand[b];
            if ($urandom_range(49) == 0) en_rand = N'($urandom);
            clr_rand = '0;
            if ($urandom_range(5) == 0) clr_rand = N'($urandom);
            step(r_rand, en_rand, clr_rand, ($urandom_range(499) == 0));
        end

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
